// File: rtl/decode_stage_if.sv
// Fetch/decode/execute bundle for the decode stage, including the register-file read port.
// The slave modport is the decode stage; the master modport is its surrounding pipeline.
interface decode_stage_if;
   logic        if_valid;
   logic [15:0] if_ir;
   logic [15:0] if_pc;
   logic        if_ready;
   logic [2:0]  rf_ra1;
   logic [2:0]  rf_ra2;
   logic [15:0] rf_rd1;
   logic [15:0] rf_rd2;
   logic        flush;
   logic        id_ready;
   logic        id_valid;
   logic [15:0] id_pc;
   logic [15:0] id_a;
   logic [15:0] id_b;
   logic [15:0] id_imm;
   logic [3:0]  id_op;
   logic [2:0]  id_rd;
   logic        id_we;
   logic        id_mem_rd;
   logic        id_mem_wr;
   logic        id_branch;
   logic        id_jump;
   logic        halt_program;
   logic        illegal;

   // Both sides use valid/ready: a transfer happens on a rising edge where valid && ready,
   // and the sender holds its payload stable while valid && !ready.
   modport slave (
      input  if_valid, if_ir, if_pc, rf_rd1, rf_rd2, flush, id_ready,
      output if_ready, rf_ra1, rf_ra2, id_valid, id_pc, id_a, id_b, id_imm, id_op, id_rd,
             id_we, id_mem_rd, id_mem_wr, id_branch, id_jump, halt_program, illegal
   );

   modport master (
      output if_valid, if_ir, if_pc, rf_rd1, rf_rd2, flush, id_ready,
      input  if_ready, rf_ra1, rf_ra2, id_valid, id_pc, id_a, id_b, id_imm, id_op, id_rd,
             id_we, id_mem_rd, id_mem_wr, id_branch, id_jump, halt_program, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Single-entry decode stage: decodes if_ir, reads operands, and holds one id_* bundle.
// Stalls on load-use hazards and execute back-pressure; HLT/illegal opcodes set sticky flags.
module decode_stage #(
   parameter bit ILLEGAL_HALTS = 1'b1
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   logic [3:0]  w_op;
   logic [2:0]  w_rd, w_rs1, w_rs2;
   logic [15:0] w_imm6, w_imm12;
   logic [2:0]  w_ra1, w_ra2;
   logic        w_use1, w_use2;
   logic        w_we, w_mrd, w_mwr, w_br, w_jmp;
   logic [15:0] w_imm;
   logic        w_is_halt, w_is_illegal;
   logic [15:0] w_a, w_b;
   logic        w_adv, w_hazard, w_if_ready, w_accept;

   logic        r_id_valid;
   logic [15:0] r_id_pc, r_id_a, r_id_b, r_id_imm;
   logic [3:0]  r_id_op;
   logic [2:0]  r_id_rd;
   logic        r_id_we, r_id_mem_rd, r_id_mem_wr, r_id_branch, r_id_jump;
   logic        r_halt, r_illegal;

   assign w_op    = bus.if_ir[15:12];
   assign w_rd    = bus.if_ir[11:9];
   assign w_rs1   = bus.if_ir[8:6];
   assign w_rs2   = bus.if_ir[5:3];
   assign w_imm6  = {{10{bus.if_ir[5]}}, bus.if_ir[5:0]};
   assign w_imm12 = {{4{bus.if_ir[11]}}, bus.if_ir[11:0]};

   // w_use1/w_use2 mark which read ports carry a real source; they gate operands and hazards.
   always_comb begin
      w_ra1        = w_rs1;
      w_ra2        = w_rs2;
      w_use1       = 1'b0;
      w_use2       = 1'b0;
      w_we         = 1'b0;
      w_mrd        = 1'b0;
      w_mwr        = 1'b0;
      w_br         = 1'b0;
      w_jmp        = 1'b0;
      w_imm        = 16'h0000;
      w_is_halt    = 1'b0;
      w_is_illegal = 1'b0;
      case (w_op)
         4'h0: w_we = 1'b0;
         4'h1, 4'h2, 4'h3, 4'h4: begin
            w_use1 = 1'b1;
            w_use2 = 1'b1;
            w_we   = 1'b1;
         end
         4'h5, 4'h6: begin
            w_use1 = 1'b1;
            w_we   = 1'b1;
            w_mrd  = (w_op == 4'h6);
            w_imm  = w_imm6;
         end
         4'h7: begin
            w_ra2  = w_rd;
            w_use1 = 1'b1;
            w_use2 = 1'b1;
            w_mwr  = 1'b1;
            w_imm  = w_imm6;
         end
         4'h8: begin
            w_ra1  = w_rd;
            w_ra2  = w_rs1;
            w_use1 = 1'b1;
            w_use2 = 1'b1;
            w_br   = 1'b1;
            w_imm  = w_imm6;
         end
         4'h9: begin
            w_jmp = 1'b1;
            w_imm = w_imm12;
         end
         4'hF:    w_is_halt    = 1'b1;
         default: w_is_illegal = 1'b1;
      endcase
   end

   assign w_a = (w_use1 && (w_ra1 != 3'd0)) ? bus.rf_rd1 : 16'h0000;
   assign w_b = (w_use2 && (w_ra2 != 3'd0)) ? bus.rf_rd2 : 16'h0000;

   assign w_adv      = !r_id_valid || bus.id_ready;
   assign w_hazard   = r_id_valid && r_id_mem_rd && (r_id_rd != 3'd0) &&
                       ((w_use1 && (w_ra1 == r_id_rd)) || (w_use2 && (w_ra2 == r_id_rd)));
   assign w_if_ready = w_adv && !w_hazard && !r_halt && !bus.flush;
   assign w_accept   = bus.if_valid && w_if_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_valid  <= 1'b0;
         r_id_pc     <= 16'h0000;
         r_id_a      <= 16'h0000;
         r_id_b      <= 16'h0000;
         r_id_imm    <= 16'h0000;
         r_id_op     <= 4'h0;
         r_id_rd     <= 3'd0;
         r_id_we     <= 1'b0;
         r_id_mem_rd <= 1'b0;
         r_id_mem_wr <= 1'b0;
         r_id_branch <= 1'b0;
         r_id_jump   <= 1'b0;
         r_halt      <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (bus.flush) begin
         r_id_valid <= 1'b0;
      end else if (w_accept) begin
         if (w_is_halt) begin
            r_id_valid <= 1'b0;
            r_halt     <= 1'b1;
         end else if (w_is_illegal) begin
            r_id_valid <= 1'b0;
            r_illegal  <= 1'b1;
            if (ILLEGAL_HALTS) r_halt <= 1'b1;
         end else begin
            r_id_valid  <= 1'b1;
            r_id_pc     <= bus.if_pc;
            r_id_a      <= w_a;
            r_id_b      <= w_b;
            r_id_imm    <= w_imm;
            r_id_op     <= w_op;
            r_id_rd     <= w_rd;
            r_id_we     <= w_we && (w_rd != 3'd0);
            r_id_mem_rd <= w_mrd;
            r_id_mem_wr <= w_mwr;
            r_id_branch <= w_br;
            r_id_jump   <= w_jmp;
         end
      end else if (w_adv) begin
         r_id_valid <= 1'b0;
      end
   end

   assign bus.if_ready     = w_if_ready;
   assign bus.rf_ra1       = w_ra1;
   assign bus.rf_ra2       = w_ra2;
   assign bus.id_valid     = r_id_valid;
   assign bus.id_pc        = r_id_pc;
   assign bus.id_a         = r_id_a;
   assign bus.id_b         = r_id_b;
   assign bus.id_imm       = r_id_imm;
   assign bus.id_op        = r_id_op;
   assign bus.id_rd        = r_id_rd;
   assign bus.id_we        = r_id_we;
   assign bus.id_mem_rd    = r_id_mem_rd;
   assign bus.id_mem_wr    = r_id_mem_wr;
   assign bus.id_branch    = r_id_branch;
   assign bus.id_jump      = r_id_jump;
   assign bus.halt_program = r_halt;
   assign bus.illegal      = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, hand-written pipeline corner sequences,
// and a random run scored against an in-order queue of expected bundles.
module tb_decode_stage;
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [3:0]  op;
      logic [2:0]  rd;
      logic        we;
      logic        mrd;
      logic        mwr;
      logic        br;
      logic        jmp;
   } bundle_t;

   typedef struct {
      logic [15:0] ir;
      bundle_t     exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] regs [8];
   int          n_tests = 0;
   int          n_fail  = 0;
   bundle_t     exp_q [$];

   always #5 clk = ~clk;

   decode_stage_if bus ();
   decode_stage #(.ILLEGAL_HALTS(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

   assign bus.rf_rd1 = regs[bus.rf_ra1];
   assign bus.rf_rd2 = regs[bus.rf_ra2];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bundle_t dut_bundle();
      return {bus.id_pc, bus.id_a, bus.id_b, bus.id_imm, bus.id_op, bus.id_rd,
              bus.id_we, bus.id_mem_rd, bus.id_mem_wr, bus.id_branch, bus.id_jump};
   endfunction

   function automatic logic [15:0] rv(input logic [2:0] r);
      return (r == 3'd0) ? 16'h0000 : regs[r];
   endfunction

   // Reference decode written straight from the instruction-set table.
   function automatic bundle_t model(input logic [15:0] ir, input logic [15:0] pc);
      bundle_t     m;
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2;
      logic [15:0] s6, s12;
      op  = ir[15:12];
      rd  = ir[11:9];
      rs1 = ir[8:6];
      rs2 = ir[5:3];
      s6  = 16'($signed(ir[5:0]));
      s12 = 16'($signed(ir[11:0]));
      m    = '0;
      m.pc = pc;
      m.op = op;
      m.rd = rd;
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4: begin m.a = rv(rs1); m.b = rv(rs2); m.we = (rd != 0); end
         4'h5: begin m.a = rv(rs1); m.imm = s6; m.we = (rd != 0); end
         4'h6: begin m.a = rv(rs1); m.imm = s6; m.we = (rd != 0); m.mrd = 1'b1; end
         4'h7: begin m.a = rv(rs1); m.b = rv(rd); m.imm = s6; m.mwr = 1'b1; end
         4'h8: begin m.a = rv(rd); m.b = rv(rs1); m.imm = s6; m.br = 1'b1; end
         4'h9: begin m.imm = s12; m.jmp = 1'b1; end
         default: m.op = op;
      endcase
      return m;
   endfunction

   function automatic bit reads_reg(input logic [15:0] ir, input logic [2:0] r);
      case (ir[15:12])
         4'h1, 4'h2, 4'h3, 4'h4: return (ir[8:6] == r) || (ir[5:3] == r);
         4'h5, 4'h6:             return (ir[8:6] == r);
         4'h7, 4'h8:             return (ir[8:6] == r) || (ir[11:9] == r);
         default:                return 1'b0;
      endcase
   endfunction

   task automatic do_reset();
      rst          = 1'b1;
      bus.if_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.id_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      vec_t    vecs [11];
      bundle_t held;
      logic    exp_valid, exp_rdy, do_pop, do_push, pending;

      regs = '{16'hDEAD, 16'h0005, 16'h0007, 16'h0030, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
      bus.if_ir = 16'h0000;
      bus.if_pc = 16'h0000;
      do_reset();

      chk("reset_id_valid", bus.id_valid, 1'b0);
      chk("reset_bundle", dut_bundle(), '0);
      chk("reset_halt", bus.halt_program, 1'b0);
      chk("reset_illegal", bus.illegal, 1'b0);
      bus.if_valid = 1'b1;
      #1;
      chk("reset_if_ready", bus.if_ready, 1'b1);
      bus.if_valid = 1'b0;
      tick();

      // ---- vector table: one instruction, check bundle, then one idle cycle ----
      vecs[0]  = '{16'h1253, '{16'h0100, 16'h0005, 16'h0007, 16'h0000, 4'h1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[1]  = '{16'h543F, '{16'h0102, 16'h0000, 16'h0000, 16'hFFFF, 4'h5, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[2]  = '{16'h1053, '{16'h0104, 16'h0005, 16'h0007, 16'h0000, 4'h1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[3]  = '{16'h2728, '{16'h0106, 16'h4444, 16'h5555, 16'h0000, 4'h2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[4]  = '{16'h3E30, '{16'h0108, 16'h0000, 16'h6666, 16'h0000, 4'h3, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[5]  = '{16'h4A40, '{16'h010A, 16'h0005, 16'h0000, 16'h0000, 4'h4, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
      vecs[6]  = '{16'h667E, '{16'h010C, 16'h0005, 16'h0000, 16'hFFFE, 4'h6, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
      vecs[7]  = '{16'h7C85, '{16'h010E, 16'h0007, 16'h6666, 16'h0005, 4'h7, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
      vecs[8]  = '{16'h885F, '{16'h0110, 16'h4444, 16'h0005, 16'h001F, 4'h8, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
      vecs[9]  = '{16'h9800, '{16'hFFFE, 16'h0000, 16'h0000, 16'hF800, 4'h9, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
      vecs[10] = '{16'h0FFF, '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'h0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
      for (int i = 0; i < 11; i++) begin
         bus.if_valid = 1'b1;
         bus.if_ir    = vecs[i].ir;
         bus.if_pc    = vecs[i].exp.pc;
         #1;
         chk($sformatf("vec%0d_if_ready", i), bus.if_ready, 1'b1);
         tick();
         bus.if_valid = 1'b0;
         chk($sformatf("vec%0d_id_valid", i), bus.id_valid, 1'b1);
         chk($sformatf("vec%0d_bundle", i), dut_bundle(), vecs[i].exp);
         tick();
      end

      // ---- load-use: LD r3 then ADD r4,r3,r1 ----
      bus.if_valid = 1'b1;
      bus.if_ir    = 16'h6640;
      bus.if_pc    = 16'h0200;
      tick();
      bus.if_ir = 16'h18C8;
      bus.if_pc = 16'h0202;
      #1;
      chk("lu_if_ready_low", bus.if_ready, 1'b0);
      tick();
      chk("lu_bubble", bus.id_valid, 1'b0);
      #1;
      chk("lu_if_ready_back", bus.if_ready, 1'b1);
      tick();
      bus.if_valid = 1'b0;
      chk("lu_add_valid", bus.id_valid, 1'b1);
      chk("lu_add_bundle", dut_bundle(), model(16'h18C8, 16'h0202));
      tick();

      // ---- execute stall for three cycles ----
      bus.if_valid = 1'b1;
      bus.if_ir    = 16'h1253;
      bus.if_pc    = 16'h0300;
      tick();
      held         = model(16'h1253, 16'h0300);
      bus.id_ready = 1'b0;
      bus.if_ir    = 16'h2728;
      bus.if_pc    = 16'h0302;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("stall%0d_if_ready", i), bus.if_ready, 1'b0);
         chk($sformatf("stall%0d_valid", i), bus.id_valid, 1'b1);
         chk($sformatf("stall%0d_bundle", i), dut_bundle(), held);
         tick();
      end
      chk("stall_hold_final", dut_bundle(), held);
      bus.id_ready = 1'b1;
      #1;
      chk("stall_release_ready", bus.if_ready, 1'b1);
      tick();
      chk("stall_next_valid", bus.id_valid, 1'b1);
      chk("stall_next_bundle", dut_bundle(), model(16'h2728, 16'h0302));

      // ---- flush overrides stall and blocks a same-cycle HLT ----
      bus.id_ready = 1'b0;
      bus.if_ir    = 16'hF000;
      bus.flush    = 1'b1;
      #1;
      chk("flush_if_ready", bus.if_ready, 1'b0);
      tick();
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      bus.id_ready = 1'b1;
      chk("flush_over_stall", bus.id_valid, 1'b0);
      chk("flush_hlt_no_halt", bus.halt_program, 1'b0);

      // ---- HLT accepted ----
      bus.if_valid = 1'b1;
      bus.if_ir    = 16'hF000;
      bus.if_pc    = 16'h0400;
      #1;
      chk("hlt_if_ready", bus.if_ready, 1'b1);
      tick();
      chk("hlt_halt", bus.halt_program, 1'b1);
      chk("hlt_not_forwarded", bus.id_valid, 1'b0);
      bus.if_ir = 16'h1253;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("halted%0d_if_ready", i), bus.if_ready, 1'b0);
         tick();
         chk($sformatf("halted%0d_valid", i), bus.id_valid, 1'b0);
      end
      do_reset();
      chk("post_hlt_reset_halt", bus.halt_program, 1'b0);

      // ---- reset asserted during a stall ----
      bus.if_valid = 1'b1;
      bus.if_ir    = 16'h2728;
      bus.if_pc    = 16'h0500;
      tick();
      bus.id_ready = 1'b0;
      bus.if_ir    = 16'h1253;
      tick();
      chk("prestall_valid", bus.id_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", bus.id_valid, 1'b0);
      chk("rst_async_bundle", dut_bundle(), '0);
      do_reset();

      // ---- illegal opcode ----
      bus.if_valid = 1'b1;
      bus.if_ir    = 16'hA000;
      tick();
      bus.if_valid = 1'b0;
      chk("illegal_flag", bus.illegal, 1'b1);
      chk("illegal_halt", bus.halt_program, 1'b1);
      chk("illegal_not_forwarded", bus.id_valid, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_clears_illegal", bus.illegal, 1'b0);
      chk("rst_clears_halt", bus.halt_program, 1'b0);
      do_reset();

      // ---- random traffic against the expected queue ----
      for (int i = 1; i < 8; i++) regs[i] = 16'($urandom);
      exp_q.delete();
      pending = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (!pending) begin
            bus.if_valid = ($urandom_range(0, 3) != 0);
            bus.if_ir    = {4'($urandom_range(0, 9)), 12'($urandom)};
            bus.if_pc    = 16'($urandom);
            pending      = bus.if_valid;
         end
         bus.id_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_valid = (exp_q.size() != 0);
         chk("rnd_valid", bus.id_valid, exp_valid);
         if (exp_valid) chk("rnd_bundle", dut_bundle(), exp_q[0]);
         exp_rdy = (!exp_valid || bus.id_ready) &&
                   !(exp_valid && exp_q[0].mrd && exp_q[0].rd != 3'd0 && reads_reg(bus.if_ir, exp_q[0].rd));
         chk("rnd_if_ready", bus.if_ready, exp_rdy);
         do_pop  = exp_valid && bus.id_ready;
         do_push = bus.if_valid && exp_rdy;
         tick();
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back(model(bus.if_ir, bus.if_pc));
            pending = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ILLEGAL_HALTS, default 1, meaning: an accepted illegal opcode also sets the sticky halt.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_valid  input  1  fetch holds a valid instruction.
REQ-005 if_ir  input  16  instruction word from fetch.
REQ-006 if_pc  input  16  address of if_ir.
REQ-007 if_ready  output  1  decode accepts if_ir this cycle.
REQ-008 rf_ra1, rf_ra2  output  3 each  register-file read addresses (combinational from if_ir).
REQ-009 rf_rd1, rf_rd2  input  16 each  register-file read data for rf_ra1/rf_ra2.
REQ-010 flush  input  1  execute redirect; discard decode contents.
REQ-011 id_ready  input  1  execute accepts the id_* bundle.
REQ-012 id_valid  output  1  id_* bundle valid.
REQ-013 id_pc, id_a, id_b, id_imm  output  16 each  pc, operand A, operand B, sign-extended immediate.
REQ-014 id_op  output  4  opcode; id_rd  output  3  destination.
REQ-015 id_we, id_mem_rd, id_mem_wr, id_branch, id_jump  output  1 each  control flags.
REQ-016 halt_program  output  1  sticky halt to fetch; illegal  output  1  sticky illegal-opcode flag.

Function
REQ-017 Encoding: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0], imm12=[11:0].
REQ-018 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR (R-type, we=1); 5 ADDI, 6 LD (rs1+imm6, we=1, LD mem_rd=1); 7 ST (mem[rs1+imm6]<=r[rd], mem_wr=1, id_b=r[rd]); 8 BEQ (rd vs rs1, target pc+imm6, branch=1); 9 JMP (pc+imm12, jump=1); F HLT; A-E illegal.
REQ-019 Immediates shall be sign-extended to 16 bits; pc-relative sums computed downstream, wrap mod 2^16.
REQ-020 Register 0 reads as 16'h0000 regardless of rf_rd*; id_we forced 0 when rd=0.
REQ-021 rf_ra1=rs1 (BEQ: rd), rf_ra2=rs2 (ST, BEQ: rd/rs1 as needed); operands latched only on acceptance.
REQ-022 Output register advances when !id_valid || id_ready ("adv").
REQ-023 Load-use hazard = id_valid && id_mem_rd && id_rd!=0 && id_rd matches a source register used by if_ir.
REQ-024 if_ready = adv && !hazard && !halt_program && !flush.
REQ-025 Accept = if_valid && if_ready; latency 1 cycle: accepted instruction appears on id_* next edge.
REQ-026 adv && !accept: id_valid<=0 (bubble); hazard therefore inserts exactly one bubble.
REQ-027 !adv: all id_* hold stable (no change while id_valid && !id_ready).
REQ-028 Accepted NOP: id_valid<=1, all control flags 0.
REQ-029 Accepted HLT: not forwarded (id_valid<=0); halt_program<=1 next edge, sticky until rst.
REQ-030 Accepted illegal opcode: not forwarded; illegal<=1 sticky; halt_program<=1 if ILLEGAL_HALTS=1.
REQ-031 flush: id_valid<=0 next edge, nothing accepted that cycle; overrides id_ready stall.
REQ-032 Once halt_program=1, no further acceptance; in-flight id_* bundle still drains via id_ready.

Reset
REQ-033 rst asserted: id_valid, all control flags, halt_program, illegal <=0; id_pc, id_a, id_b, id_imm <=16'h0000; id_op, id_rd <=0; immediate, independent of clk, mid-stall included.
REQ-034 After rst deasserts, if_ready=1 on the first cycle with if_valid.

Verification
REQ-035 Bench: if_ir=16'h1253 (ADD r1,r1,r2), r1=5,r2=7, id_ready=1 -> next cycle id_valid=1, id_op=1, id_rd=1, id_a=5, id_b=7, id_we=1.
REQ-036 Bench: LD r3 then ADD r4,r3,r1 back-to-back -> if_ready=0 one cycle, one bubble (id_valid=0), ADD issues next cycle.
REQ-037 Bench: id_ready=0 three cycles with bundle valid -> id_* unchanged, if_ready=0; release -> next instruction issued.
REQ-038 Bench: HLT (16'hF000) accepted -> halt_program=1 next cycle, if_ready=0 thereafter; HLT with flush same cycle -> halt_program stays 0.
REQ-039 Bench: ADDI r2,r0,-1 (16'h543F) -> id_a=0, id_imm=16'hFFFF; rd=0 ADD -> id_we=0.
REQ-040 Bench: opcode 16'hA000 -> illegal=1, halt_program=1; rst mid-stall -> all outputs zero immediately.
